// File: rtl/life_pkg.sv
// Shared constants, FSM state type and DDR address packing for the Game of Life generation path.
package life_pkg;

  localparam int WORDS_PER_ROW = 40;
  localparam int WORD_W        = 16;
  localparam int ROW_W         = 9;
  localparam int WORD_IDX_W    = 6;
  localparam int ADDR_W        = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0]      row,
                                                  input logic [WORD_IDX_W-1:0] word);
    return {9'h000, row, word};
  endfunction

endpackage

// File: rtl/life_word_rule.sv
// Next-generation rule for one word of cells; each slice carries the left neighbour
// in bit 0 and the right neighbour in bit W+1 around the W cells of interest.
module life_word_rule
  import life_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W+1:0] above,
  input  logic [W+1:0] center,
  input  logic [W+1:0] below,
  output logic [W-1:0] next
);

  logic [3:0] n;

  always_comb begin
    next = '0;
    n    = '0;
    for (int unsigned i = 0; i < W; i++) begin
      n = {3'b000, above[i]}  + {3'b000, above[i+1]}  + {3'b000, above[i+2]} +
          {3'b000, center[i]}                         + {3'b000, center[i+2]} +
          {3'b000, below[i]}  + {3'b000, below[i+1]}  + {3'b000, below[i+2]};
      next[i] = (n == 4'd3) | (center[i+1] & (n == 4'd2));
    end
  end

endmodule

// File: rtl/life_next_gen.sv
// Streams row r-1/r/r+1 word triples, computes the next generation of row r and
// issues one DDR write per word in ascending order with valid/ack handshaking.
module life_next_gen
  import life_pkg::*;
#(
  parameter int WORDS_PER_ROW = 40,
  parameter int WORD_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WORD_W-1:0] inAbove,
  input  logic [WORD_W-1:0] inCenter,
  input  logic [WORD_W-1:0] inBelow,
  input  logic [ROW_W-1:0]  inRow,
  output logic              outWrite,
  input  logic              outAck,
  output logic [ADDR_W-1:0] outAddress,
  output logic [WORD_W-1:0] outData,
  output logic              busy
);

  state_t                  state;
  logic [WORD_IDX_W-1:0]   word_cnt;
  logic [ROW_W-1:0]        row_q;
  logic [WORD_W-1:0]       a_prev, a_cur, c_prev, c_cur, b_prev, b_cur;
  logic [WORD_W-1:0]       a_next, c_next, b_next;
  logic [3*WORD_W-1:0]     win_a, win_c, win_b;
  logic [WORD_W-1:0]       next_word;
  logic                    accept;
  logic                    last_in;

  always_comb begin
    case (state)
      IDLE, FILL: inReady = 1'b1;
      RUN:        inReady = !outWrite;
      default:    inReady = 1'b0;
    endcase
  end

  assign accept  = inValid && inReady;
  assign last_in = (word_cnt == WORD_IDX_W'(WORDS_PER_ROW - 1));
  assign busy    = (state != IDLE) | outWrite;

  // After the last word arrives there is no right neighbour: feed zeros instead of the bus.
  assign a_next = (state == FLUSH) ? '0 : inAbove;
  assign c_next = (state == FLUSH) ? '0 : inCenter;
  assign b_next = (state == FLUSH) ? '0 : inBelow;

  assign win_a = {a_next, a_cur, a_prev};
  assign win_c = {c_next, c_cur, c_prev};
  assign win_b = {b_next, b_cur, b_prev};

  life_word_rule #(.W(WORD_W)) u_rule (
    .above  (win_a[2*WORD_W:WORD_W-1]),
    .center (win_c[2*WORD_W:WORD_W-1]),
    .below  (win_b[2*WORD_W:WORD_W-1]),
    .next   (next_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      row_q      <= '0;
      a_prev     <= '0;
      a_cur      <= '0;
      c_prev     <= '0;
      c_cur      <= '0;
      b_prev     <= '0;
      b_cur      <= '0;
      outWrite   <= 1'b0;
      outAddress <= '0;
      outData    <= '0;
    end else begin
      if (outWrite && outAck)
        outWrite <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            row_q    <= inRow;
            a_prev   <= '0;
            c_prev   <= '0;
            b_prev   <= '0;
            a_cur    <= inAbove;
            c_cur    <= inCenter;
            b_cur    <= inBelow;
            word_cnt <= WORD_IDX_W'(1);
            state    <= FILL;
          end
        end

        FILL, RUN: begin
          if (accept) begin
            a_prev     <= a_cur;
            c_prev     <= c_cur;
            b_prev     <= b_cur;
            a_cur      <= inAbove;
            c_cur      <= inCenter;
            b_cur      <= inBelow;
            outWrite   <= 1'b1;
            outAddress <= pack_addr(row_q, word_cnt - 1'b1);
            outData    <= next_word;
            if (last_in) begin
              word_cnt <= '0;
              state    <= FLUSH;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= RUN;
            end
          end
        end

        FLUSH: begin
          // Retiring the previous write and loading the final word share one edge.
          if (!outWrite || outAck) begin
            outWrite   <= 1'b1;
            outAddress <= pack_addr(row_q, WORD_IDX_W'(WORDS_PER_ROW - 1));
            outData    <= next_word;
            state      <= DRAIN;
          end
        end

        DRAIN: begin
          if (!outWrite || outAck)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_next_gen.sv
// Directed bench for life_next_gen: table of single-row patterns with hand-computed
// next-generation words, plus backpressure and mid-row reset sequences.
module tb_life_next_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [15:0] inAbove, inCenter, inBelow;
  logic [8:0]  inRow;
  logic        outWrite;
  logic        outAck;
  logic [23:0] outAddress;
  logic [15:0] outData;
  logic        busy;

  life_next_gen #(.WORDS_PER_ROW(40), .WORD_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .inValid    (inValid),
    .inReady    (inReady),
    .inAbove    (inAbove),
    .inCenter   (inCenter),
    .inBelow    (inBelow),
    .inRow      (inRow),
    .outWrite   (outWrite),
    .outAck     (outAck),
    .outAddress (outAddress),
    .outData    (outData),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  row;
    int unsigned ia;
    logic [15:0] a0, c0, b0;
    int unsigned ib;
    logic [15:0] a1, c1, b1;
    int unsigned ea;
    logic [15:0] e0;
    int unsigned eb;
    logic [15:0] e1;
    bit          stall;
    bit          busy_chk;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] ab[40], cb[40], bb[40], ex[40];
  logic [23:0] wa_q[$];
  logic [15:0] wd_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Each write is recorded mid-cycle, just before the edge that consumes its ack.
  always @(negedge clk) begin
    if (!rst && outWrite && outAck) begin
      wa_q.push_back(outAddress);
      wd_q.push_back(outData);
    end
  end

  task automatic clear_row();
    for (int i = 0; i < 40; i++) begin
      ab[i] = '0; cb[i] = '0; bb[i] = '0; ex[i] = '0;
    end
  endtask

  task automatic run_row(input logic [8:0] row, input bit stall,
                         input int unsigned stop_after, input bit busy_chk);
    int unsigned k = 0;
    int unsigned cyc = 0;
    int unsigned stall_left = stall ? 10 : 0;
    logic [23:0] held_a = '0;
    logic [15:0] held_d = '0;
    bit          busy_done = 1'b0;
    bit          acc;
    while (cyc < 2000) begin
      if (stall && outWrite && outAddress[5:0] == 6'd12 && stall_left > 0) begin
        if (stall_left == 10) begin
          held_a = outAddress;
          held_d = outData;
        end else begin
          check("stall_addr", outAddress, held_a);
          check("stall_data", outData, held_d);
        end
        check("stall_write", outWrite, 1);
        check("stall_ready", inReady, 0);
        outAck = 1'b0;
        stall_left--;
      end else begin
        outAck = 1'b1;
      end
      if (k < stop_after) begin
        inValid  = 1'b1;
        inAbove  = ab[k];
        inCenter = cb[k];
        inBelow  = bb[k];
        inRow    = (k == 0) ? row : 9'h1FF;
      end else begin
        inValid = 1'b0;
        if (stop_after < 40) return;
        if (!busy) break;
      end
      @(negedge clk);
      acc = inValid && inReady;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        k++;
        if (k == 2) begin
          check("first_write_valid", outWrite, 1);
          check("first_write_addr", outAddress, {9'h000, row, 6'd0});
        end
      end
      if (busy_chk && wd_q.size() == 40 && !busy_done) begin
        check("busy_fall", busy, 0);
        busy_done = 1'b1;
      end
    end
    if (cyc >= 2000) check("row_timeout", 1, 0);
  endtask

  task automatic compare_row(input logic [8:0] row);
    check("write_count", wa_q.size(), 40);
    for (int i = 0; i < 40 && i < wa_q.size(); i++) begin
      check("write_addr", wa_q[i], {9'h000, row, 6'(i)});
      check("write_data", wd_q[i], ex[i]);
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    vecs[0] = '{9'd5,   0,  16'h0000, 16'h000E, 16'h0000, 0,  16'h0000, 16'h000E, 16'h0000,
                0,  16'h0004, 0,  16'h0004, 1'b0, 1'b0};
    vecs[1] = '{9'd3,   0,  16'h8000, 16'h8000, 16'h8000, 1,  16'h0001, 16'h0001, 16'h0001,
                0,  16'h4000, 1,  16'h0002, 1'b0, 1'b0};
    vecs[2] = '{9'd9,   39, 16'h8000, 16'h8000, 16'h8000, 39, 16'h8000, 16'h8000, 16'h8000,
                39, 16'hC000, 0,  16'h0000, 1'b0, 1'b0};
    vecs[3] = '{9'd2,   12, 16'h0000, 16'h000E, 16'h0000, 12, 16'h0000, 16'h000E, 16'h0000,
                12, 16'h0004, 12, 16'h0004, 1'b1, 1'b0};
    vecs[4] = '{9'd100, 20, 16'h0002, 16'h0004, 16'h0007, 20, 16'h0002, 16'h0004, 16'h0007,
                20, 16'h0005, 20, 16'h0005, 1'b0, 1'b0};
    vecs[5] = '{9'd0,   0,  16'h0000, 16'h0000, 16'h0000, 0,  16'h0000, 16'h0000, 16'h0000,
                0,  16'h0000, 0,  16'h0000, 1'b0, 1'b1};

    rst = 1'b1; inValid = 1'b0; outAck = 1'b0;
    inAbove = '0; inCenter = '0; inBelow = '0; inRow = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", inReady, 1);
    check("rst_write", outWrite, 0);
    check("rst_addr", outAddress, 0);
    check("rst_data", outData, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      clear_row();
      ab[vecs[v].ia] = vecs[v].a0; cb[vecs[v].ia] = vecs[v].c0; bb[vecs[v].ia] = vecs[v].b0;
      ab[vecs[v].ib] = vecs[v].a1; cb[vecs[v].ib] = vecs[v].c1; bb[vecs[v].ib] = vecs[v].b1;
      ex[vecs[v].ea] = vecs[v].e0;
      ex[vecs[v].eb] = vecs[v].e1;
      run_row(vecs[v].row, vecs[v].stall, 40, vecs[v].busy_chk);
      compare_row(vecs[v].row);
    end

    // Abort row 11 once word 20 is in, then run row 7 from scratch.
    clear_row();
    cb[20] = 16'h0FF0;
    run_row(9'd11, 1'b0, 21, 1'b0);
    inValid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_write", outWrite, 0);
    check("midrst_ready", inReady, 1);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wa_q.delete();
    wd_q.delete();
    clear_row();
    run_row(9'd7, 1'b0, 40, 1'b0);
    compare_row(9'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
